// File: rtl/spi_slave_burst.sv
// SPI slave front-end: deserialises {cmd[1:0], payload} frames and serialises controller read words on miso.
// Latency: rx_valid/frame_err one cycle after the deciding sample edge; read MSB on miso the cycle after tx_valid.
// Backpressure: none on the serial side; WAIT_TX stalls for tx_valid up to TX_TIMEOUT cycles, then flags an error.
module spi_slave_burst #(
  parameter int DATA_W     = 8,
  parameter int TX_TIMEOUT = 15,
  parameter bit BURST_EN   = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ss_n,
  input  logic              mosi,
  output logic              miso,
  output logic [DATA_W+1:0] rx_data,
  output logic              rx_valid,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              frame_err,
  output logic              busy
);

  // Frame geometry and counter limits. DATA_W is assumed to be at least 2.
  localparam int FRAME_W = DATA_W + 2;
  localparam int CNT_W   = $clog2(DATA_W + 3);
  localparam int TMO_W   = $clog2(TX_TIMEOUT + 1);

  localparam logic [CNT_W-1:0] LAST_RX_BIT = CNT_W'(FRAME_W - 1);
  localparam logic [CNT_W-1:0] LAST_TX_BIT = CNT_W'(DATA_W - 1);
  localparam logic [TMO_W-1:0] TMO_LIMIT   = TMO_W'(TX_TIMEOUT);

  localparam logic [1:0] CMD_RD_ADDR = 2'b10;
  localparam logic [1:0] CMD_RD_DATA = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RECV,
    ST_WAIT_TX,
    ST_SEND,
    ST_DRAIN
  } state_t;

  state_t              state_q,     state_d;
  logic [CNT_W-1:0]    bit_cnt_q,   bit_cnt_d;    // bits received in RECV, bits sent in SEND
  logic [TMO_W-1:0]    tmo_cnt_q,   tmo_cnt_d;    // cycles spent in WAIT_TX
  logic [FRAME_W-2:0]  rx_sr_q,     rx_sr_d;      // all but the final bit; the last bit comes straight from mosi
  logic [DATA_W-1:0]   tx_sr_q,     tx_sr_d;
  logic [FRAME_W-1:0]  rx_data_q,   rx_data_d;
  logic                rx_valid_q,  rx_valid_d;
  logic                frame_err_q, frame_err_d;
  logic                rd_armed_q,  rd_armed_d;   // a read-address frame has been seen and not yet consumed

  // Frame as it would look if the current mosi sample completes it.
  logic [FRAME_W-1:0]  rx_word;
  logic [1:0]          rx_cmd;
  logic [TMO_W-1:0]    tmo_next;

  assign rx_word  = {rx_sr_q, mosi};
  assign rx_cmd   = rx_word[FRAME_W-1 -: 2];
  assign tmo_next = tmo_cnt_q + TMO_W'(1);

  // State and datapath registers; synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      bit_cnt_q   <= '0;
      tmo_cnt_q   <= '0;
      rx_sr_q     <= '0;
      tx_sr_q     <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      rd_armed_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      tmo_cnt_q   <= tmo_cnt_d;
      rx_sr_q     <= rx_sr_d;
      tx_sr_q     <= tx_sr_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
      rd_armed_q  <= rd_armed_d;
    end
  end

  // Next-state and datapath updates; ss_n high out of any active state wins over everything else.
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    tmo_cnt_d   = tmo_cnt_q;
    rx_sr_d     = rx_sr_q;
    tx_sr_d     = tx_sr_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;
    frame_err_d = 1'b0;
    rd_armed_d  = rd_armed_q;

    unique case (state_q)
      ST_IDLE: begin
        if (!ss_n) begin
          state_d   = ST_RECV;
          bit_cnt_d = '0;
          rx_sr_d   = '0;
        end
      end

      ST_RECV: begin
        if (ss_n) begin
          // RECV is left on the final bit, so a deselect here always means a short frame.
          state_d     = ST_IDLE;
          frame_err_d = 1'b1;
        end else begin
          rx_sr_d   = rx_word[FRAME_W-2:0];
          bit_cnt_d = bit_cnt_q + CNT_W'(1);
          if (bit_cnt_q == LAST_RX_BIT) begin
            if (rx_cmd != CMD_RD_DATA) begin
              rx_data_d  = rx_word;
              rx_valid_d = 1'b1;
              state_d    = ST_DRAIN;
              if (rx_cmd == CMD_RD_ADDR) begin
                rd_armed_d = 1'b1;
              end
            end else if (rd_armed_q) begin
              rx_data_d  = rx_word;
              rx_valid_d = 1'b1;
              rd_armed_d = 1'b0;
              tmo_cnt_d  = '0;
              state_d    = ST_WAIT_TX;
            end else begin
              // Read data without a preceding read address: reject the frame.
              frame_err_d = 1'b1;
              state_d     = ST_DRAIN;
            end
          end
        end
      end

      ST_WAIT_TX: begin
        if (ss_n) begin
          state_d = ST_IDLE;
        end else if (tx_valid) begin
          tx_sr_d   = tx_data;
          bit_cnt_d = '0;
          state_d   = ST_SEND;
        end else begin
          tmo_cnt_d = tmo_next;
          if (tmo_next == TMO_LIMIT) begin
            frame_err_d = 1'b1;
            state_d     = ST_DRAIN;
          end
        end
      end

      ST_SEND: begin
        if (ss_n) begin
          // bit_cnt_q+1 bits have been on the wire by this edge.
          state_d     = ST_IDLE;
          frame_err_d = (bit_cnt_q < LAST_TX_BIT);
        end else begin
          tx_sr_d   = {tx_sr_q[DATA_W-2:0], 1'b0};
          bit_cnt_d = bit_cnt_q + CNT_W'(1);
          if (bit_cnt_q == LAST_TX_BIT) begin
            if (BURST_EN) begin
              tmo_cnt_d = '0;
              state_d   = ST_WAIT_TX;
            end else begin
              state_d   = ST_DRAIN;
            end
          end
        end
      end

      ST_DRAIN: begin
        if (ss_n) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Outputs: miso only carries data in SEND, everything else is registered state.
  assign miso      = (state_q == ST_SEND) ? tx_sr_q[DATA_W-1] : 1'b0;
  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign frame_err = frame_err_q;
  assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_spi_slave_burst.sv
// Randomised bench for spi_slave_burst with a transaction-level reference model.
// Inputs driven on the falling edge, outputs checked on the falling edge after each rising edge.
// Every wait is a fixed number of cycles, so the run always terminates.
module tb_spi_slave_burst;

  localparam int DW  = 8;
  localparam int N   = DW + 2;
  localparam int TMO = 15;

  logic          clk;
  logic          rst_n;
  logic          ss_n;
  logic          mosi;
  logic          miso;
  logic [N-1:0]  rx_data;
  logic          rx_valid;
  logic [DW-1:0] tx_data;
  logic          tx_valid;
  logic          frame_err;
  logic          busy;

  int            n_chk = 0;
  int            n_err = 0;

  // Reference model state: rd_armed flag and the word rx_data should hold.
  bit            armed = 1'b0;
  logic [N-1:0]  exp_rx = '0;

  spi_slave_burst #(
    .DATA_W     (DW),
    .TX_TIMEOUT (TMO),
    .BURST_EN   (1'b1)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ss_n      (ss_n),
    .mosi      (mosi),
    .miso      (miso),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .frame_err (frame_err),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, then advance to the next falling edge.
  task automatic tick(input logic ss, input logic mo, input logic tv, input logic [DW-1:0] td);
    ss_n     = ss;
    mosi     = mo;
    tx_valid = tv;
    tx_data  = td;
    @(posedge clk);
    @(negedge clk);
  endtask

  // One frame from IDLE. nb < N deselects early. Returns in_wait=1 when the slave now waits for tx data.
  task automatic frame(input logic [1:0] cmd, input logic [DW-1:0] pl, input int nb, output bit in_wait);
    logic [N-1:0] bits;
    bit           acc;
    bits    = {cmd, pl};
    in_wait = 1'b0;
    tick(1'b0, 1'($urandom), 1'b0, DW'($urandom));
    chk("sel_busy", busy, 1);
    chk("sel_rxv", rx_valid, 0);
    for (int i = 0; i < nb; i++) begin
      tick(1'b0, bits[N-1-i], 1'b0, DW'($urandom));
      if (i < N - 1) begin
        chk("rx_bit_rxv", rx_valid, 0);
        chk("rx_bit_ferr", frame_err, 0);
        chk("rx_bit_miso", miso, 0);
      end
    end
    if (nb < N) begin
      tick(1'b1, 1'($urandom), 1'b0, DW'($urandom));
      chk("short_ferr", frame_err, 1);
      chk("short_rxv", rx_valid, 0);
      chk("short_busy", busy, 0);
      tick(1'b1, 1'($urandom), 1'b0, DW'($urandom));
      chk("short_ferr_clr", frame_err, 0);
      chk("short_rxd", rx_data, exp_rx);
    end else begin
      acc = (cmd != 2'b11) || armed;
      chk("done_rxv", rx_valid, acc);
      chk("done_ferr", frame_err, !acc);
      chk("done_miso", miso, 0);
      if (acc) exp_rx = bits;
      chk("done_rxd", rx_data, exp_rx);
      if (cmd == 2'b10) armed = 1'b1;
      else if (cmd == 2'b11 && acc) armed = 1'b0;
      if (cmd == 2'b11 && acc) begin
        in_wait = 1'b1;
      end else begin
        tick(1'b0, 1'($urandom), 1'b0, DW'($urandom));
        chk("drain_rxv", rx_valid, 0);
        chk("drain_ferr", frame_err, 0);
        chk("drain_busy", busy, 1);
        chk("drain_miso", miso, 0);
        tick(1'b1, 1'($urandom), 1'b0, DW'($urandom));
        chk("end_busy", busy, 0);
        chk("end_ferr", frame_err, 0);
      end
    end
  endtask

  // From WAIT_TX: idle dly cycles, hand over d, watch it go out MSB first. nbits < DW deselects mid-word.
  task automatic read_word(input logic [DW-1:0] d, input int dly, input int nbits);
    for (int c = 0; c < dly; c++) begin
      tick(1'b0, 1'($urandom), 1'b0, DW'($urandom));
      chk("wait_miso", miso, 0);
      chk("wait_ferr", frame_err, 0);
      chk("wait_busy", busy, 1);
    end
    tick(1'b0, 1'($urandom), 1'b1, d);
    for (int i = 0; i < nbits; i++) begin
      chk("send_miso", miso, d[DW-1-i]);
      chk("send_ferr", frame_err, 0);
      chk("send_rxv", rx_valid, 0);
      if (i == nbits - 1 && nbits < DW) tick(1'b1, 1'($urandom), 1'b0, DW'($urandom));
      else tick(1'b0, 1'($urandom), 1'b0, DW'($urandom));
    end
    if (nbits < DW) begin
      chk("abort_ferr", frame_err, 1);
      chk("abort_busy", busy, 0);
      chk("abort_miso", miso, 0);
      tick(1'b1, 1'($urandom), 1'b0, DW'($urandom));
      chk("abort_ferr_clr", frame_err, 0);
    end else begin
      chk("after_send_miso", miso, 0);
      chk("after_send_busy", busy, 1);
    end
  endtask

  // From WAIT_TX: either deselect cleanly or let the timeout expire.
  task automatic end_wait(input bit timeout);
    if (!timeout) begin
      tick(1'b1, 1'($urandom), 1'b0, DW'($urandom));
      chk("clean_ferr", frame_err, 0);
      chk("clean_busy", busy, 0);
    end else begin
      for (int c = 0; c < TMO - 1; c++) begin
        tick(1'b0, 1'($urandom), 1'b0, DW'($urandom));
        chk("tmo_pre_ferr", frame_err, 0);
      end
      tick(1'b0, 1'($urandom), 1'b0, DW'($urandom));
      chk("tmo_ferr", frame_err, 1);
      chk("tmo_busy", busy, 1);
      chk("tmo_miso", miso, 0);
      tick(1'b0, 1'($urandom), 1'b0, DW'($urandom));
      chk("tmo_ferr_clr", frame_err, 0);
      chk("drain_busy", busy, 1);
      tick(1'b1, 1'($urandom), 1'b0, DW'($urandom));
      chk("tmo_end_busy", busy, 0);
      chk("tmo_end_ferr", frame_err, 0);
    end
  endtask

  initial begin
    bit w;
    int op, nw, mode;
    rst_n    = 1'b0;
    ss_n     = 1'b1;
    mosi     = 1'b0;
    tx_valid = 1'b0;
    tx_data  = '0;
    @(negedge clk);
    tick(1'b1, 1'b0, 1'b0, '0);
    tick(1'b0, 1'b1, 1'b1, 8'hFF);
    chk("rst_miso", miso, 0);
    chk("rst_rxd", rx_data, 0);
    chk("rst_rxv", rx_valid, 0);
    chk("rst_ferr", frame_err, 0);
    chk("rst_busy", busy, 0);
    rst_n = 1'b1;
    tick(1'b1, 1'b0, 1'b0, '0);

    // Write address 00_1010_0101.
    frame(2'b00, 8'hA5, N, w);
    chk("wa_rxd", rx_data, 10'h0A5);

    // Read address, then read data returning 0xC3.
    frame(2'b10, 8'h03, N, w);
    chk("ra_rxd", rx_data, 10'h203);
    frame(2'b11, 8'h5A, N, w);
    chk("rd_wait", w, 1);
    read_word(8'hC3, 0, DW);
    end_wait(1'b0);

    // Read data with the arm already consumed.
    frame(2'b11, 8'h77, N, w);
    chk("unarmed_no_wait", w, 0);

    // Burst of two words, then a clean deselect in WAIT_TX.
    frame(2'b10, 8'h10, N, w);
    frame(2'b11, 8'h00, N, w);
    read_word(8'h12, 2, DW);
    read_word(8'h34, 1, DW);
    end_wait(1'b0);

    // Controller never answers.
    frame(2'b10, 8'h20, N, w);
    frame(2'b11, 8'h21, N, w);
    end_wait(1'b1);

    // Deselect after five bits.
    frame(2'b01, 8'hF0, 5, w);

    // Re-arming twice is not an error.
    frame(2'b10, 8'h01, N, w);
    frame(2'b10, 8'h02, N, w);

    // Reset in the middle of SEND.
    frame(2'b11, 8'h33, N, w);
    tick(1'b0, 1'b0, 1'b1, 8'hFF);
    chk("pre_rst_miso", miso, 1);
    rst_n = 1'b0;
    tick(1'b0, 1'b0, 1'b0, '0);
    exp_rx = '0;
    armed  = 1'b0;
    chk("rst_send_miso", miso, 0);
    chk("rst_send_busy", busy, 0);
    chk("rst_send_rxd", rx_data, 0);
    chk("rst_send_rxv", rx_valid, 0);
    chk("rst_send_ferr", frame_err, 0);
    rst_n = 1'b1;
    tick(1'b1, 1'b0, 1'b0, '0);
    frame(2'b11, 8'h44, N, w);

    // Reset in the middle of RECV leaves no trace.
    frame(2'b01, 8'h5C, N, w);
    tick(1'b0, 1'b0, 1'b0, '0);
    for (int i = 0; i < 4; i++) tick(1'b0, 1'($urandom), 1'b0, '0);
    rst_n = 1'b0;
    tick(1'b0, 1'b1, 1'b0, '0);
    exp_rx = '0;
    armed  = 1'b0;
    rst_n  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick(1'b1, 1'b0, 1'b0, '0);
      chk("post_rst_rxv", rx_valid, 0);
      chk("post_rst_ferr", frame_err, 0);
      chk("post_rst_rxd", rx_data, 0);
    end

    // Random traffic.
    for (int t = 0; t < 60; t++) begin
      op = $urandom_range(0, 4);
      case (op)
        0: frame(2'($urandom_range(0, 1)), DW'($urandom), N, w);
        1: frame(2'b10, DW'($urandom), N, w);
        2: frame(2'($urandom), DW'($urandom), $urandom_range(1, N - 1), w);
        default: begin
          frame(2'b11, DW'($urandom), N, w);
          if (w) begin
            nw   = $urandom_range(1, 3);
            mode = $urandom_range(0, 2);
            for (int k = 0; k < nw; k++) begin
              if (k == nw - 1 && mode == 1) read_word(DW'($urandom), $urandom_range(0, TMO - 1), $urandom_range(1, DW - 1));
              else read_word(DW'($urandom), $urandom_range(0, TMO - 1), DW);
            end
            if (mode != 1) end_wait(mode == 2);
          end
        end
      endcase
      tick(1'b1, 1'($urandom), 1'b0, DW'($urandom));
      chk("idle_busy", busy, 0);
      chk("idle_rxd", rx_data, exp_rx);
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/spi_slave_burst.md
# spi_slave_burst

Parametrised SPI slave front-end placed between an external SPI master and the on-chip RAM/register controller.
- Deserialises command frames of 2 command bits plus DATA_W payload bits into `rx_data`.
- Serialises read data from the controller onto `miso` using a `tx_valid` handshake.
- Adds burst reads, a transmit-wait timeout, and frame-error reporting.
- Serial bits are sampled on system `clk`; `ss_n` and `mosi` are synchronous to `clk`.

## Interface
- DATA_W, 8: payload width. Frame length is DATA_W+2 bits.
- TX_TIMEOUT, 15: maximum number of cycles spent in WAIT_TX before a timeout error. Must be ≥1.
- BURST_EN, 1: 1 means further data words are streamed while `ss_n` stays low. 0 means a single word per read.
- clk  in  1  system clock. Reset is rst_n, synchronous, active-low; clock is clk.
- rst_n  in  1  synchronous active-low reset.
- ss_n  in  1  slave select, active low.
- mosi  in  1  serial data in, MSB first.
- miso  out  1  serial data out, MSB first.
- rx_data  out  DATA_W+2  received frame as {cmd[1:0], payload}.
- rx_valid  out  1  one-cycle strobe indicating `rx_data` is valid.
- tx_data  in  DATA_W  read word from the controller.
- tx_valid  in  1  `tx_data` is valid. Sampled only in WAIT_TX.
- frame_err  out  1  one-cycle error strobe.
- busy  out  1  high whenever the state is not IDLE.

## Operation
- States: IDLE, RECV, WAIT_TX, SEND, DRAIN.
- Commands:
  - 00: write address.
  - 01: write data.
  - 10: read address. Sets `rd_armed`.
  - 11: read data. Requires `rd_armed`.
- IDLE:
  - `ss_n`=0 → RECV; bit counter cleared; shift register cleared.
- RECV:
  - Each cycle with `ss_n`=0, shift `mosi` into the LSB and increment the counter.
  - On the (DATA_W+2)th bit:
    - cmd≠11: load `rx_data`, pulse `rx_valid`, → DRAIN.
    - cmd=11 and `rd_armed`: load `rx_data`, pulse `rx_valid`, clear `rd_armed`, → WAIT_TX.
    - cmd=11 and not `rd_armed`: no `rx_valid`, pulse `frame_err`, → DRAIN.
- WAIT_TX:
  - `tx_valid`=1: capture `tx_data` into the tx shift register, → SEND.
  - Cycle counter reaches TX_TIMEOUT without `tx_valid`: pulse `frame_err`, → DRAIN.
- SEND:
  - `miso` = tx_sr[DATA_W-1]; shift left each cycle for DATA_W cycles.
  - After the last bit: BURST_EN=1 and `ss_n`=0 → WAIT_TX (timeout counter reset). Otherwise → DRAIN.
- DRAIN: ignore `mosi` until `ss_n`=1.
- `ss_n`=1 in any non-IDLE state → IDLE on the next edge, which takes priority over every other transition.
  - Pulse `frame_err` if the state was RECV with fewer than DATA_W+2 bits received, or SEND with fewer than DATA_W bits sent.
  - `ss_n`=1 in WAIT_TX or DRAIN is a clean end and raises no error.
- `rd_armed` persists across frames. It is cleared only by reset or by a consumed 11 frame. A second 10 frame re-arms it with no error.
- Bit counter width: $clog2(DATA_W+3); no wrap inside a frame.

## Timing
- Reset values: `miso`=0, `rx_data`=0, `rx_valid`=0, `frame_err`=0, `busy`=0, state=IDLE, `rd_armed`=0.
- If `ss_n` low is first sampled at edge E0, payload bits are sampled at edges E1..E(DATA_W+2).
- `rx_valid` is high for exactly the one cycle following E(DATA_W+2).
- `rx_data` holds its value until the next completed frame or reset.
- `tx_valid` sampled high at edge T moves the state to SEND.
  - The MSB is on `miso` during the cycle after T.
  - Bit i is on `miso` during cycle T+1+i.
- `miso` is 0 in every state except SEND.
- `frame_err` is high for exactly one cycle, registered.
- Reset asserted mid-frame returns all outputs to their reset values on that edge. A partial frame yields no `rx_valid` after reset is released.

## Test plan
- Write address, DATA_W=8, bits 00_1010_0101 → `rx_data`=10'h0A5, `rx_valid` high for one cycle after the 10th sampled bit, `miso` stays 0.
- Read address 10_0000_0011, then in a new frame read data 11_xxxx_xxxx with `tx_valid`=1 and `tx_data`=8'hC3 at WAIT_TX → `miso` serialises 1,1,0,0,0,0,1,1 starting the cycle after `tx_valid` is sampled.
- Read data frame with no prior read address → no `rx_valid`, `frame_err` pulses once, `miso` stays 0.
- Burst with BURST_EN=1 and `ss_n` held low: `tx_data` 8'h12 then 8'h34 → 16 bits 0x12, 0x34 on `miso`; `ss_n` high in WAIT_TX → no `frame_err`.
- `tx_valid` never asserted → `frame_err` pulses after TX_TIMEOUT=15 cycles in WAIT_TX; state goes to DRAIN and then to IDLE on `ss_n` high.
- `ss_n` rises after 5 bits in RECV → `frame_err` pulse, no `rx_valid`, IDLE next cycle. Also: `rst_n`=0 mid-SEND → all outputs return to 0 on that edge.
